// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: MEM/WB bundle layout and load-type encodings.
package wb_stage_pkg;

  localparam int MEM_DATA_W   = 74;

  // Bundle is {RegWrite, MemtoReg[3:0], rd[4:0], result[31:0], data_sram_rdata[31:0]}, MSB first
  localparam int RDATA_LSB    = 0;
  localparam int RESULT_LSB   = 32;
  localparam int RD_LSB       = 64;
  localparam int MEMTOREG_LSB = 69;
  localparam int REGWRITE_BIT = 73;

  typedef enum logic [3:0] {
    LD_NONE = 4'd0,
    LD_B    = 4'd1,
    LD_H    = 4'd2,
    LD_W    = 4'd3,
    LD_BU   = 4'd4,
    LD_HU   = 4'd5
  } ld_type_e;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load-data lane selection and sign/zero extension; codes 6..15 fall back to the ALU result.
module wb_stage_load_ext
  import wb_stage_pkg::*;
(
  input  logic [3:0]  mem_to_reg,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] result,
  output logic [31:0] wdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Misaligned halfwords just pick the half addressed by off[1]
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wdata = result;
    case (mem_to_reg)
      LD_NONE: wdata = result;
      LD_B:    wdata = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    wdata = {{16{half_sel[15]}}, half_sel};
      LD_W:    wdata = rdata;
      LD_BU:   wdata = {24'd0, byte_sel};
      LD_HU:   wdata = {16'd0, half_sel};
      default: wdata = result;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32 writeback stage: MEM/WB register with valid/allowin handshake, load extension,
// register-file write port, WB forwarding outputs and retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_DATA_W-1:0] mem_stage_data,
  input  logic                  ms_to_ws_valid,
  output logic                  ws_allowin,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [4:0]            ws_rd,
  output logic [XLEN-1:0]       ws_fd_data,
  output logic [CNT_W-1:0]      instret
);

  logic                  ws_valid_q, ws_valid_d;
  logic [MEM_DATA_W-1:0] bundle_q, bundle_d;
  logic [CNT_W-1:0]      instret_q, instret_d;

  logic                  reg_write;
  logic [3:0]            mem_to_reg;
  logic [4:0]            rd;
  logic [31:0]           result;
  logic [31:0]           rdata;
  logic [31:0]           ext_data;
  logic                  retire;

  assign reg_write  = bundle_q[REGWRITE_BIT];
  assign mem_to_reg = bundle_q[MEMTOREG_LSB +: 4];
  assign rd         = bundle_q[RD_LSB +: 5];
  assign result     = bundle_q[RESULT_LSB +: 32];
  assign rdata      = bundle_q[RDATA_LSB +: 32];

  assign ws_allowin = !ws_valid_q || !stall;
  assign retire     = ws_valid_q && !stall;

  always_comb begin
    ws_valid_d = ws_valid_q;
    bundle_d   = bundle_q;
    instret_d  = instret_q;
    // The resident instruction retires even when the incoming one is flushed
    if (retire) instret_d = instret_q + CNT_W'(1);
    if (flush) begin
      ws_valid_d = 1'b0;
    end else if (ws_allowin) begin
      ws_valid_d = ms_to_ws_valid;
      if (ms_to_ws_valid) bundle_d = mem_stage_data;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_valid_q <= 1'b0;
      bundle_q   <= '0;
      instret_q  <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      bundle_q   <= bundle_d;
      instret_q  <= instret_d;
    end
  end

  wb_stage_load_ext u_load_ext (
    .mem_to_reg (mem_to_reg),
    .off        (result[1:0]),
    .rdata      (rdata),
    .result     (result),
    .wdata      (ext_data)
  );

  assign rf_we      = retire && reg_write && (rd != 5'd0);
  assign rf_waddr   = rd;
  assign rf_wdata   = ext_data;
  assign ws_fd_data = ext_data;
  // Forwarding stays visible through a stall so dependents keep bypassing
  assign ws_rd      = (ws_valid_q && reg_write) ? rd : 5'd0;
  assign instret    = instret_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage RV32 pipeline; sits directly downstream of the mem stage and consumes its `MEM_DATA` bundle.
- Contains the MEM/WB pipeline register with a valid/allowin handshake and stall/flush control.
- Does load-data byte/halfword extraction and sign/zero extension, and drives the register-file write port.
- Provides WB forwarding data to the hazard unit and keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- mem_stage_data  in  `MEM_DATA` (74)  bundle {RegWrite, MemtoReg[3:0], rd[4:0], result[31:0], data_sram_rdata[31:0]}, MSB first.
- ms_to_ws_valid  in  1  mem stage holds a valid instruction.
- ws_allowin  out  1  WB can accept a new instruction this cycle.
- stall  in  1  hold WB; the instruction in WB does not retire.
- flush  in  1  discard the incoming instruction; the WB register becomes invalid.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- ws_rd  out  5  forwarding destination; 0 when there is nothing to forward.
- ws_fd_data  out  32  forwarding data, equal to rf_wdata.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- The pipeline register holds ws_valid plus the full 74-bit bundle.
- Reset: ws_valid=0, bundle=0, instret=0.
  - Outputs after reset: rf_we=0, ws_rd=0, rf_waddr=0, rf_wdata=0, ws_allowin=1.
- ws_allowin = !ws_valid || !stall. This path is combinational.
- retire = ws_valid && !stall.
- Next-state priority:
  1. rst
  2. flush: ws_valid<=0, bundle unchanged
  3. ws_allowin: ws_valid<=ms_to_ws_valid; bundle<=mem_stage_data only when ms_to_ws_valid=1
  4. otherwise hold
- Flush in the same cycle as a retire: the current instruction still retires (rf_we asserted, instret incremented). Only the incoming instruction is dropped.
- Latency: an instruction accepted at edge N drives rf_we/rf_wdata during cycle N+1 when not stalled.
- The write is committed by the regfile at edge N+1.
- rf_we = retire && RegWrite && (rd != 0). Writes to x0 are suppressed.
- rf_waddr = rd.
- MemtoReg encoding (load type); off = result[1:0]:
  - 0 NONE: result
  - 1 LB: sign-extend rdata byte[off]
  - 2 LH: sign-extend rdata half[off[1]]
  - 3 LW: rdata; off ignored
  - 4 LBU: zero-extend byte[off]
  - 5 LHU: zero-extend half[off[1]]
  - 6..15: treated as NONE (result)
- Misaligned halfword (off=1 or 3) uses off[1] only. There is no trap.
- ws_rd = (ws_valid && RegWrite) ? rd : 0.
  - ws_rd remains valid during stall so the hazard unit keeps forwarding.
  - ws_fd_data = the extended write data.
- instret increments by 1 on every retire, including instructions with RegWrite=0 (stores, branches).
  - It wraps modulo 2^CNT_W.
- rst asserted mid-stall clears everything; the pending instruction is lost.

Decomposition:
- pipeline.vh holds:
  - `MEM_DATA` width.
  - Bundle field offsets.
  - MemtoReg encodings: `LD_NONE`, `LD_B`, `LD_H`, `LD_W`, `LD_BU`, `LD_HU`.
- One sub-module, load_ext: purely combinational.
  - Inputs: MemtoReg, off, rdata, result.
  - Output: wdata.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then valid=0 → rf_we=0, ws_rd=0, ws_allowin=1, instret=0.
- ALU write: bundle {RegWrite=1, MemtoReg=0, rd=5, result=0x1234_5678} valid 1 cycle → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, instret=1.
- Load extension, rdata=0x80FF_7F01, RegWrite=1, rd=7:
  - LB off=3 → 0xFFFFFF80
  - LBU off=1 → 0x0000007F
  - LH off=2 → 0xFFFF80FF
  - LHU off=0 → 0x00007F01
  - LW off=2 → 0x80FF7F01
- x0 suppression: RegWrite=1, rd=0 → rf_we=0, ws_rd=0, instret still increments.
- Stall: instruction in WB, stall=1 for 3 cycles with ms_to_ws_valid=1.
  - Each stalled cycle: ws_allowin=0, rf_we=0, ws_rd held, instret unchanged.
  - On release: one retire, then the new instruction is captured.
- Flush collision: ws_valid=1, stall=0, flush=1, ms_to_ws_valid=1 → current instruction writes (rf_we=1), next cycle ws_valid=0, rf_we=0, instret +1 only.
